// File: rtl/pu_read_arbiter.sv
// Round-robin owner of the shared buffer-read port, one burst per grant.
// Optional watchdog abort built only when PU_ARB_WATCHDOG_EN is defined.
module pu_read_arbiter #(
  parameter int NUM_PU  = 4,
  parameter int BURST_W = 8,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PU-1:0]          pu_req,
  input  logic [NUM_PU*BURST_W-1:0]  pu_burst_len,
  output logic [NUM_PU-1:0]          pu_grant,
  output logic [NUM_PU-1:0]          pu_read_last,
  output logic                       mem_rd_req,
  input  logic                       mem_rd_ready,
  output logic [ID_W-1:0]            mem_rd_id,
  output logic [BURST_W-1:0]         mem_rd_len,
  input  logic                       mem_rd_beat,
  output logic                       busy,
  output logic                       err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    XFER,
    RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [BURST_W-1:0]  len_q, len_d;
  logic [NUM_PU-1:0]   grant_q, grant_d;
  logic [BURST_W:0]    beat_q, beat_d;

  logic [ID_W-1:0]     sel_idx;
  logic                sel_vld;
  int unsigned         arb_idx;
  logic [BURST_W:0]    len_m1;
  logic                last_beat;
  logic                timeout;
  logic                done;

  // Circular search: walk down so the lowest offset from rr_ptr wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    arb_idx = 0;
    for (int k = NUM_PU - 1; k >= 0; k--) begin
      arb_idx = (int'(rr_ptr_q) + k) % NUM_PU;
      if (pu_req[arb_idx]) begin
        sel_vld = 1'b1;
        sel_idx = ID_W'(arb_idx);
      end
    end
  end

  // A zero length means a full 2^BURST_W beat burst.
  assign len_m1 = {(len_q == '0), len_q}
                - {{BURST_W{1'b0}}, 1'b1};

  assign last_beat = (state_q == XFER)
                   && mem_rd_beat
                   && (beat_q == len_m1);

`ifdef PU_ARB_WATCHDOG_EN
  logic [9:0] idle_q, idle_d;
  logic       err_q;

  assign timeout = ((state_q == CMD) || (state_q == XFER))
                 && (idle_q == 10'h3FF);

  always_comb begin
    idle_d = idle_q + 10'd1;
    if ((state_q == IDLE) || (state_q == RELEASE))
      idle_d = '0;
    else if ((state_q == CMD) && mem_rd_ready)
      idle_d = '0;
    else if ((state_q == XFER) && mem_rd_beat)
      idle_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      if (timeout)
        err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign done = last_beat | timeout;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    len_d    = len_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = CMD;
          id_d    = sel_idx;
          len_d   = pu_burst_len[sel_idx*BURST_W +: BURST_W];
          grant_d = {{(NUM_PU-1){1'b0}}, 1'b1} << sel_idx;
        end
      end
      CMD: begin
        if (timeout) begin
          state_d = RELEASE;
          grant_d = '0;
        end else if (mem_rd_ready) begin
          state_d = XFER;
          beat_d  = '0;
        end
      end
      XFER: begin
        if (done) begin
          state_d = RELEASE;
          grant_d = '0;
        end else if (mem_rd_beat) begin
          beat_d = beat_q + {{BURST_W{1'b0}}, 1'b1};
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        rr_ptr_d = (id_q == ID_W'(NUM_PU - 1))
                 ? '0 : id_q + ID_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      len_q    <= '0;
      grant_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      len_q    <= len_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
    end
  end

  // Final-beat pulse goes only to the current owner, never during reset.
  assign pu_read_last = (done && !reset) ? grant_q : '0;
  assign pu_grant     = grant_q;
  assign mem_rd_req   = (state_q == CMD);
  assign mem_rd_id    = id_q;
  assign mem_rd_len   = len_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pu_read_arbiter.sv
// Bench for pu_read_arbiter: burst-level reference model plus
// directed scenarios with literal expectations.
module tb_pu_read_arbiter;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    pu_req;
  logic [N*BW-1:0] pu_burst_len;
  logic [N-1:0]    pu_grant;
  logic [N-1:0]    pu_read_last;
  logic            mem_rd_req;
  logic            mem_rd_ready;
  logic [IW-1:0]   mem_rd_id;
  logic [BW-1:0]   mem_rd_len;
  logic            mem_rd_beat;
  logic            busy;
  logic            err_timeout;

  pu_read_arbiter #(.NUM_PU(N), .BURST_W(BW), .ID_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .pu_req       (pu_req),
    .pu_burst_len (pu_burst_len),
    .pu_grant     (pu_grant),
    .pu_read_last (pu_read_last),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_id    (mem_rd_id),
    .mem_rd_len   (mem_rd_len),
    .mem_rd_beat  (mem_rd_beat),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  bit auto_drop = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Burst-level model: owner, phase flags, beats remaining.
  int m_owner = -1;
  bit m_cmd   = 1'b0;
  bit m_rel   = 1'b0;
  int m_left  = 0;
  int m_nxt   = 0;
  int m_idle  = 0;
  bit m_err   = 1'b0;
  int m_len   = 0;

  function automatic bit m_to();
`ifdef PU_ARB_WATCHDOG_EN
    return (m_owner >= 0) && !m_rel && (m_idle == 1023);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_last();
    return (m_owner >= 0) && !m_rel && !m_cmd
        && mem_rd_beat && (m_left == 1);
  endfunction

  task automatic model_step();
    bit to;
    bit lst;
    to  = m_to();
    lst = m_last();
    if (reset) begin
      m_owner = -1; m_cmd = 0; m_rel = 0; m_left = 0;
      m_nxt = 0; m_idle = 0; m_err = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_nxt + k) % N;
        if (pu_req[p]) begin
          m_owner = p;
          m_cmd   = 1;
          m_idle  = 0;
          m_len   = int'(pu_burst_len[p*BW +: BW]);
          m_left  = (m_len == 0) ? 256 : m_len;
          break;
        end
      end
    end else if (m_rel) begin
      m_nxt   = (m_owner + 1) % N;
      m_owner = -1;
      m_rel   = 0;
    end else if (to) begin
      m_err = 1; m_rel = 1; m_cmd = 0;
    end else if (m_cmd) begin
      if (mem_rd_ready) begin
        m_cmd = 0; m_idle = 0;
      end else m_idle++;
    end else if (lst) begin
      m_rel = 1;
    end else if (mem_rd_beat) begin
      m_left--; m_idle = 0;
    end else m_idle++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Event log used by literal checks.
  int          gorder[$];
  int          rl_count[N];
  int          rl_cyc[N];
  logic [N-1:0] rl_latched = '0;
  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] erl;
    eg  = '0;
    erl = '0;
    if (m_owner >= 0 && !m_rel) eg[m_owner] = 1'b1;
    if (m_owner >= 0 && (m_last() || m_to()) && !reset)
      erl[m_owner] = 1'b1;
    if (chk_en) begin
      chk("grant", pu_grant, eg);
      chk("read_last", pu_read_last, erl);
      chk("busy", busy, m_owner >= 0);
      chk("mem_rd_req", mem_rd_req, m_cmd);
      chk("err_timeout", err_timeout, m_err);
      if (m_cmd) begin
        chk("mem_rd_id", mem_rd_id, m_owner);
        chk("mem_rd_len", mem_rd_len, m_len);
      end
    end
    if (pu_grant != '0 && prev_grant == '0)
      for (int i = 0; i < N; i++)
        if (pu_grant[i]) gorder.push_back(i);
    for (int i = 0; i < N; i++)
      if (pu_read_last[i]) begin
        if (rl_count[i] == 0) rl_cyc[i] = cyc;
        rl_count[i]++;
      end
    prev_grant = pu_grant;
    rl_latched = pu_read_last;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop) pu_req = pu_req & ~rl_latched;
  endtask

  task automatic clear_log();
    gorder.delete();
    for (int i = 0; i < N; i++) begin
      rl_count[i] = 0;
      rl_cyc[i]   = -1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pu_req = '0;
    step();
    step();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic set_len(int p, int l);
    pu_burst_len[p*BW +: BW] = BW'(l);
  endtask

  task automatic wait_rl(string nm, int p, int n, int maxc);
    int k;
    k = 0;
    while (rl_count[p] < n && k < maxc) begin
      step();
      k++;
    end
    chk(nm, rl_count[p] >= n, 1);
  endtask

  initial begin
    int t0;
    int exp_ord[5];
    exp_ord = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    pu_req = '0;
    pu_burst_len = '0;
    mem_rd_ready = 1'b0;
    mem_rd_beat = 1'b0;
    clear_log();
    step();
    step();
    chk_en = 1'b1;
    chk("rst_grant", pu_grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_rd_req, 0);
    reset = 1'b0;

    // Single PU, len 4, ready and beats always high.
    do_reset();
    set_len(0, 4);
    mem_rd_ready = 1'b1;
    mem_rd_beat = 1'b1;
    pu_req = 4'b0001;
    t0 = cyc;
    step();
    chk("t1_grant_c1", pu_grant, 4'b0001);
    chk("t1_req_c1", mem_rd_req, 1);
    wait_rl("t1_wait", 0, 1, 20);
    chk("t1_rl_cyc", rl_cyc[0] - t0, 5);
    chk("t1_rel_grant", pu_grant, 0);
    chk("t1_rel_busy", busy, 1);
    step();
    chk("t1_idle_busy", busy, 0);
    step();
    chk("t1_no_regrant", busy, 0);

    // All four requesting, len 2; PU0 re-requests.
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 2);
    pu_req = 4'b1111;
    wait_rl("t2_wait0", 0, 1, 40);
    pu_req[0] = 1'b1;
    wait_rl("t2_wait0b", 0, 2, 60);
    step();
    step();
    chk("t2_ord_sz", gorder.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t2_ord", (i < gorder.size()) ? gorder[i] : -1,
          exp_ord[i]);
    chk("t2_rl0", rl_count[0], 2);
    for (int i = 1; i < N; i++) chk("t2_rl", rl_count[i], 1);

    // Owner drops request mid-burst; PU1 queued.
    do_reset();
    set_len(2, 6);
    set_len(1, 3);
    mem_rd_ready = 1'b0;
    mem_rd_beat = 1'b0;
    pu_req = 4'b0100;
    repeat (3) step();
    mem_rd_ready = 1'b1;
    step();
    mem_rd_ready = 1'b0;
    repeat (2) begin
      mem_rd_beat = 1'b1;
      step();
      mem_rd_beat = 1'b0;
      step();
    end
    pu_req = 4'b0010;
    mem_rd_ready = 1'b1;
    mem_rd_beat = 1'b1;
    wait_rl("t3_wait2", 2, 1, 30);
    wait_rl("t3_wait1", 1, 1, 30);
    repeat (5) step();
    chk("t3_rl2", rl_count[2], 1);
    chk("t3_ord_sz", gorder.size(), 2);
    chk("t3_ord1", (gorder.size() > 1) ? gorder[1] : -1, 1);
    chk("t3_idle", busy, 0);

    // len 0 means 256 beats.
    do_reset();
    set_len(1, 0);
    pu_req = 4'b0010;
    t0 = cyc;
    repeat (4) step();
    chk("t4_no_early", rl_count[1], 0);
    wait_rl("t4_wait", 1, 1, 300);
    chk("t4_rl_cyc", rl_cyc[1] - t0, 257);

    // Reset mid-burst at beat 2 of 8.
    do_reset();
    set_len(3, 8);
    pu_req = 4'b1000;
    repeat (3) step();
    reset = 1'b1;
    pu_req = '0;
    step();
    reset = 1'b0;
    chk("t5_grant", pu_grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_no_rl", rl_count[3], 0);
    set_len(1, 2);
    pu_req = 4'b1010;
    wait_rl("t5_wait1", 1, 1, 20);
    chk("t5_ord_sz", gorder.size(), 2);
    chk("t5_ord1", (gorder.size() > 1) ? gorder[1] : -1, 1);
    wait_rl("t5_wait3", 3, 1, 30);

    // Memory never accepts the command.
    do_reset();
    set_len(0, 4);
    mem_rd_ready = 1'b0;
    mem_rd_beat = 1'b0;
    pu_req = 4'b0001;
    t0 = cyc;
    repeat (1100) step();
`ifdef PU_ARB_WATCHDOG_EN
    chk("t6_rl", rl_count[0], 1);
    chk("t6_rl_cyc", rl_cyc[0] - t0, 1024);
    chk("t6_err", err_timeout, 1);
    chk("t6_idle", busy, 0);
`else
    chk("t6_rl", rl_count[0], 0);
    chk("t6_err", err_timeout, 0);
    chk("t6_busy", busy, 1);
    chk("t6_cmd", mem_rd_req, 1);
`endif
    do_reset();
    chk("t6_rst_err", err_timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule
